// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared FSM encoding and default sizes for the memory bus arbiter.
package mips_mem_pkg;
   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int STARVE_MAX_DEF = 4;
   typedef enum logic [2:0] {IDLE, ISSUE_I, ISSUE_D, RESP_I, RESP_D} arb_state_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: data-first grant decision with a starvation cap that protects instruction fetch.
module arb_starve_cnt
   import mips_mem_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_idle,
   input  logic i_inst_ce,
   input  logic i_data_ce,
   output logic o_gnt_i,
   output logic o_gnt_d
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             w_cap_ok;
   always_comb begin
      w_cap_ok = r_cnt < CNT_W'(STARVE_MAX);
      o_gnt_d  = i_idle & i_data_ce & (w_cap_ok | ~i_inst_ce);
      o_gnt_i  = i_idle & i_inst_ce & ~o_gnt_d;
   end
   // count only data grants that made a waiting fetch wait longer
   always_ff @(posedge clk or posedge rst)
      if (rst) r_cnt <= '0;
      else if (~i_inst_ce | o_gnt_i) r_cnt <= '0;
      else if (o_gnt_d & w_cap_ok) r_cnt <= r_cnt + CNT_W'(1);
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port synchronous RAM between the fetch and load/store
// ports; every access takes issue + response cycles after the grant.
module mem_bus_arbiter
   import mips_mem_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_ce_i,
   input  logic [ADDR_W-1:0] inst_addr_i,
   output logic [DATA_W-1:0] inst_data_o,
   output logic              inst_ready_o,
   input  logic              data_ce_i,
   input  logic              data_we_i,
   input  logic [3:0]        data_sel_i,
   input  logic [ADDR_W-1:0] data_addr_i,
   input  logic [DATA_W-1:0] data_wdata_i,
   output logic [DATA_W-1:0] data_rdata_o,
   output logic              data_ready_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [3:0]        mem_sel_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              stall_req_o
);
   arb_state_t        r_state;
   logic              r_we;
   logic [3:0]        r_sel;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_inst_hold;
   logic [DATA_W-1:0] r_data_hold;
   logic              w_idle;
   logic              w_gnt_i;
   logic              w_gnt_d;
   logic              w_issue;

   assign w_idle  = r_state == IDLE;
   assign w_issue = (r_state == ISSUE_I) | (r_state == ISSUE_D);

   arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_idle    (w_idle),
      .i_inst_ce (inst_ce_i),
      .i_data_ce (data_ce_i),
      .o_gnt_i   (w_gnt_i),
      .o_gnt_d   (w_gnt_d)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_state     <= IDLE;
         r_we        <= 1'b0;
         r_sel       <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_inst_hold <= '0;
         r_data_hold <= '0;
      end else
         case (r_state)
            IDLE:
               if (w_gnt_d) begin
                  r_we    <= data_we_i;
                  r_sel   <= data_sel_i;
                  r_addr  <= data_addr_i;
                  r_wdata <= data_wdata_i;
                  r_state <= ISSUE_D;
               end else if (w_gnt_i) begin
                  r_we    <= 1'b0;
                  r_sel   <= 4'hF;
                  r_addr  <= inst_addr_i;
                  r_wdata <= '0;
                  r_state <= ISSUE_I;
               end
            ISSUE_I: r_state <= RESP_I;
            ISSUE_D: r_state <= RESP_D;
            RESP_I: begin
               r_inst_hold <= mem_rdata_i;
               r_state     <= IDLE;
            end
            RESP_D: begin
               if (!r_we) r_data_hold <= mem_rdata_i;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase

   // RAM data is only valid in the response cycle; stores leave the load hold untouched
   always_comb begin
      mem_ce_o     = w_issue;
      mem_we_o     = w_issue & r_we;
      mem_sel_o    = w_issue ? r_sel : '0;
      mem_addr_o   = w_issue ? r_addr : '0;
      mem_wdata_o  = w_issue ? r_wdata : '0;
      inst_ready_o = r_state == RESP_I;
      data_ready_o = r_state == RESP_D;
      inst_data_o  = inst_ready_o ? mem_rdata_i : r_inst_hold;
      data_rdata_o = (data_ready_o & ~r_we) ? mem_rdata_i : r_data_hold;
      stall_req_o  = (inst_ce_i & ~inst_ready_o) | (data_ce_i & ~data_ready_o);
   end
endmodule
